// File: rtl/tune_mode_scheduler.sv
// Time-shares the frequency-drive path between the TR, TX and TP tuning loops.
// Round-robin grant with minimum dwell (in data_valid strobes) and a parked guard gap.
module tune_mode_scheduler #(
  parameter int unsigned W      = 32,
  parameter int unsigned DWELL  = 64,
  parameter int unsigned GUARD  = 4,
  parameter int unsigned F_PARK = 6000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         data_valid_i,
  input  logic         req_tr_i,
  input  logic         req_tx_i,
  input  logic         req_tp_i,
  input  logic [W-1:0] f_tr_i,
  input  logic [W-1:0] f_tx_i,
  input  logic [W-1:0] f_tp_i,
  output logic         tr_mode_o,
  output logic         tx_mode_o,
  output logic         tp_mode_o,
  output logic [W-1:0] freq_out_o,
  output logic         freq_valid_o,
  output logic [1:0]   owner_o
);

  localparam int unsigned DwW = $clog2(DWELL + 1);
  localparam int unsigned GdW = $clog2(GUARD + 1);
  localparam logic [DwW-1:0] DwellMax  = DwW'(DWELL);
  localparam logic [GdW-1:0] GuardInit = GdW'(GUARD);
  localparam logic [W-1:0]   FPark     = W'(F_PARK);

  typedef enum logic [1:0] {StIdle, StActive, StGuard} state_e;

  state_e         state_q, state_d;
  logic [2:0]     mode_q, mode_d;     // bit 0 TR, bit 1 TX, bit 2 TP
  logic [1:0]     owner_q, owner_d;
  logic [1:0]     last_q, last_d;
  logic [DwW-1:0] dwell_q, dwell_d;
  logic [GdW-1:0] guard_q, guard_d;
  logic [W-1:0]   freq_q, freq_d;
  logic           fvalid_q, fvalid_d;

  logic [2:0]     req_v;
  logic           own_req;
  logic           other_req;
  logic [1:0]     winner;
  logic [W-1:0]   f_own;

  // First requester strictly after the last owner, in TR -> TX -> TP order.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
    logic [3:0] req4;
    logic [1:0] c;
    req4    = {req, 1'b0};
    c       = last;
    rr_pick = 2'd0;
    for (int i = 0; i < 3; i++) begin
      c = (c == 2'd3) ? 2'd1 : c + 2'd1;
      if (rr_pick == 2'd0 && req4[c]) begin
        rr_pick = c;
      end
    end
  endfunction

  always_comb begin
    req_v     = {req_tp_i, req_tx_i, req_tr_i};
    own_req   = |(req_v & mode_q);
    other_req = |(req_v & ~mode_q);
    winner    = rr_pick(last_q, req_v);
    case (owner_q)
      2'd1:    f_own = f_tr_i;
      2'd2:    f_own = f_tx_i;
      2'd3:    f_own = f_tp_i;
      default: f_own = FPark;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    owner_d  = owner_q;
    last_d   = last_q;
    dwell_d  = dwell_q;
    guard_d  = guard_q;
    freq_d   = freq_q;
    fvalid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (winner != 2'd0) begin
          state_d = StActive;
          owner_d = winner;
          mode_d  = 3'b001 << (winner - 2'd1);
          dwell_d = '0;
        end
      end
      StActive: begin
        // Owner drop takes priority; a strobe on the exit clock is discarded.
        if (!own_req || (dwell_q == DwellMax && other_req)) begin
          state_d = StGuard;
          mode_d  = 3'b000;
          owner_d = 2'd0;
          last_d  = owner_q;
          guard_d = GuardInit;
          freq_d  = FPark;
        end else if (data_valid_i) begin
          if (dwell_q != DwellMax) begin
            dwell_d = dwell_q + DwW'(1);
          end
          freq_d   = f_own;
          fvalid_d = 1'b1;
        end
      end
      StGuard: begin
        // Leaving on the last count makes the ungranted gap GUARD+1 clocks.
        guard_d = guard_q - GdW'(1);
        if (guard_q <= GdW'(1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      mode_q   <= 3'b000;
      owner_q  <= 2'd0;
      last_q   <= 2'd3;
      dwell_q  <= '0;
      guard_q  <= '0;
      freq_q   <= FPark;
      fvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      dwell_q  <= dwell_d;
      guard_q  <= guard_d;
      freq_q   <= freq_d;
      fvalid_q <= fvalid_d;
    end
  end

  assign tr_mode_o    = mode_q[0];
  assign tx_mode_o    = mode_q[1];
  assign tp_mode_o    = mode_q[2];
  assign owner_o      = owner_q;
  assign freq_out_o   = freq_q;
  assign freq_valid_o = fvalid_q;

endmodule

// File: doc/tune_mode_scheduler.md
Name: tune_mode_scheduler

Overview:
- Time-shares the single frequency-drive path between the three tuning loops: TR_AUTO (TR), TX and TP.
- Grants exactly one loop at a time by driving its tr_mode/tx_mode/tp_mode enable.
- Muxes the granted loop's frequency word onto the shared output.
- Enforces a minimum dwell and a parked guard gap between grants. Sits between the host mode-request logic and the TR/TX/TP instances.

Parameters:
- W, 32, width of the frequency words and of freq_out.
- DWELL, 64, minimum data_valid strobes a grant is held before it can be preempted (must be >= 1).
- GUARD, 4, clocks with no grant and parked output between two grants (must be >= 1).
- F_PARK, 6000, freq_out value while idle or in guard (F1 of the loops).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous reset, active-low.
- data_valid  in  1  one-clock sample strobe shared by the loops (1 in 5 clocks typical).
- req_tr  in  1  level request for the TR loop.
- req_tx  in  1  level request for the TX loop.
- req_tp  in  1  level request for the TP loop.
- f_tr  in  W  TR loop frequency word.
- f_tx  in  W  TX loop frequency word.
- f_tp  in  W  TP loop frequency word.
- tr_mode  out  1  TR loop enable (grant).
- tx_mode  out  1  TX loop enable (grant).
- tp_mode  out  1  TP loop enable (grant).
- freq_out  out  W  registered shared frequency word.
- freq_valid  out  1  one-clock pulse when freq_out is updated from a loop.
- owner  out  2  0 none, 1 TR, 2 TX, 3 TP.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all mode outputs 0; owner=0.
  - freq_out=F_PARK; freq_valid=0; dwell counter 0.
  - RR pointer = TP, so TR wins first.
- Reset mid-grant: the mode output drops immediately (async). After release the block restarts from IDLE.
- All outputs are registered. Mode outputs are one-hot or all-zero at every clock.
- IDLE:
  - If any req is high, pick the winner round-robin, starting after the last owner: order TR -> TX -> TP -> TR.
  - Next clock: state=ACTIVE, winner's mode=1, owner set, dwell=0.
  - Request-to-grant latency = 1 clock.
- ACTIVE:
  - Each data_valid increments dwell, saturating at DWELL.
  - On each data_valid: freq_out <= owner's f_*; freq_valid=1 on the following clock (one-cycle registered latency, in step with freq_out).
  - freq_valid is 0 otherwise.
- ACTIVE exit conditions (evaluated each clock):
  - a) Owner's req low: leave immediately, regardless of dwell.
  - b) dwell==DWELL and another req is high: preempt.
  - Otherwise hold the grant indefinitely. A sole requester is never preempted.
- On exit: state=GUARD, mode outputs 0 on the next clock, freq_out <= F_PARK, RR pointer = old owner, guard counter = GUARD.
- data_valid arriving on the exit clock is ignored (no freq update, no freq_valid).
- GUARD:
  - Counts down once per clock, with all modes 0 and owner=0.
  - At 0: go to IDLE arbitration. Grant appears on the clock after the guard ends, so the gap is exactly GUARD+1 clocks with no mode high.
  - Requests changing during GUARD are only sampled at arbitration.
  - If no req is pending at arbitration: remain IDLE, parked.
- Simultaneous events:
  - Several reqs at arbitration: the RR order decides.
  - Owner req drop plus preempt condition on the same clock: treated as exit (a). Same outcome.
- Counters: dwell needs ceil(log2(DWELL+1)) bits; guard needs ceil(log2(GUARD+1)) bits. No wrap-around (saturate or stop at limit).
- F_PARK is truncated/zero-extended to W bits.

Test Plan:
- Reset release with req_tr=1 only, f_tr=7000 -> tr_mode=1 one clock after the first sampled clock. Each data_valid gives freq_out=7000 and freq_valid=1 one clock later. tx_mode=tp_mode=0 throughout.
- Contention: req_tr=req_tx=req_tp=1 from reset, DWELL=64, GUARD=4.
  - TR is held for 64 data_valid (~320 clocks).
  - Then 5 clocks with all modes 0 and freq_out=6000.
  - Then TX, then TP, then TR. Each owner gets >= 64 strobes.
- Owner drop: TX granted with dwell=10, req_tx falls -> tx_mode=0 next clock, freq_out=6000, 5-clock gap, then the pending TP is granted.
- Sole requester: req_tp=1 only for 2000 clocks -> tp_mode held continuously. Dwell saturates at 64 with no glitch and no guard entry.
- Async reset asserted mid-ACTIVE (TR owner, between clock edges) -> tr_mode=0, freq_out=6000, owner=0 without waiting for clk. After release with req_tx=1 only -> TX is granted.
- No requests after a grant ends -> block stays IDLE, freq_out=6000, freq_valid never pulses, for 1000 clocks.
